// File: rtl/uart_rx.sv
// 8N1 serial byte receiver, LSB first, mid-bit sampled from a clock-derived bit timer.
// Emits registered byte/framing-error strobes and a retriggerable link-activity indicator.
module uart_rx #(
   parameter int CLKRATE   = 12_000_000,
   parameter int BAUDRATE  = 9600,
   parameter int LINK_HOLD = CLKRATE / 10
) (
   input  logic       osc,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       link
);

   localparam int DIV  = CLKRATE / BAUDRATE;
   localparam int HALF = DIV / 2;
   localparam int TW   = $clog2(DIV);
   localparam int LW   = $clog2(LINK_HOLD + 1);

   localparam logic [TW-1:0] TMR_FULL = TW'(DIV - 1);
   localparam logic [TW-1:0] TMR_HALF = TW'(HALF - 1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [LW-1:0] LNK_LOAD = LW'(LINK_HOLD);
   localparam logic [LW-1:0] LNK_ONE  = LW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic [LW-1:0] lnk_q, lnk_d;
   logic          link_q, link_d;
   logic          rxs_s;
   logic          tmr_zero_s;

   assign rxs_s      = sync_q[1];
   assign tmr_zero_s = (tmr_q == '0);

   // Two-stage synchronizer for the asynchronous rx pin; idles high out of reset.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   // Frame FSM: next state, bit timer, shift register and strobe generation.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs_s) begin
               tmr_d   = TMR_HALF;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (!tmr_zero_s) begin
               tmr_d = tmr_q - TMR_ONE;
            end else if (!rxs_s) begin
               tmr_d   = TMR_FULL;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (!tmr_zero_s) begin
               tmr_d = tmr_q - TMR_ONE;
            end else begin
               shift_d = {rxs_s, shift_q[7:1]};
               tmr_d   = TMR_FULL;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (!tmr_zero_s) begin
               tmr_d = tmr_q - TMR_ONE;
            end else if (rxs_s) begin
               data_d  = shift_q;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = S_BREAK;
            end
         end
         S_BREAK: begin
            // A line held low after a bad stop bit must not re-trigger a frame.
            if (rxs_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Link hold timer: reloads on every good byte, saturates at zero.
   always_comb begin
      lnk_d = lnk_q;
      if (valid_d) begin
         lnk_d = LNK_LOAD;
      end else if (lnk_q != '0) begin
         lnk_d = lnk_q - LNK_ONE;
      end else begin
         lnk_d = '0;
      end
      link_d = (lnk_d != '0);
   end

   // State and output registers.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         lnk_q   <= '0;
         link_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         lnk_q   <= lnk_d;
         link_q  <= link_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign link      = link_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level event model predicts strobes, data and link
// every cycle, and directed literal checks pin the model on the key scenarios.
module tb_uart_rx;

   localparam int DIV     = 16;
   localparam int LATENCY = 155;   // 2 + 8 + 9*16 + 1
   localparam int HOLD    = 40;

   logic       osc;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       link;

   uart_rx #(.CLKRATE(16), .BAUDRATE(1), .LINK_HOLD(40)) dut (
      .osc(osc), .rst_n(rst_n), .rx(rx), .data(data),
      .valid(valid), .frame_err(frame_err), .link(link)
   );

   initial osc = 1'b0;
   always #5 osc = ~osc;

   int cyc = 0;
   always @(posedge osc) cyc <= cyc + 1;

   typedef struct {
      int         at;
      bit         ok;
      logic [7:0] d;
   } evt_t;

   evt_t       evq[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_valid = 0;
   int         n_ferr = 0;
   int         last_valid_cyc = -1000;
   int         last_ferr_cyc = -1000;
   logic [7:0] exp_data = 8'h00;
   int         link_end = -1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the frame-level model.
   initial begin
      bit exp_v, exp_f;
      forever begin
         @(negedge osc);
         #1;
         if (!rst_n) begin
            evq.delete();
            exp_data = 8'h00;
            link_end = -1;
            check("rst_valid", int'(valid), 0);
            check("rst_ferr", int'(frame_err), 0);
            check("rst_link", int'(link), 0);
            check("rst_data", int'(data), 0);
         end else begin
            exp_v = 1'b0;
            exp_f = 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
               if (evq[0].ok) begin
                  exp_v    = 1'b1;
                  exp_data = evq[0].d;
                  link_end = cyc + HOLD - 1;
               end else begin
                  exp_f = 1'b1;
               end
               void'(evq.pop_front());
            end
            if (valid === 1'b1) begin
               n_valid++;
               last_valid_cyc = cyc;
            end
            if (frame_err === 1'b1) begin
               n_ferr++;
               last_ferr_cyc = cyc;
            end
            check("valid", int'(valid), int'(exp_v));
            check("frame_err", int'(frame_err), int'(exp_f));
            check("data", int'(data), int'(exp_data));
            check("link", int'(link), int'(cyc <= link_end));
         end
      end
   end

   task automatic level(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         rx = v;
         @(negedge osc);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
      evt_t e;
      e.at = cyc + LATENCY;
      e.ok = stop_ok;
      e.d  = b;
      evq.push_back(e);
      level(1'b0, DIV);
      for (int i = 0; i < 8; i++) level(b[i], DIV);
      level(stop_ok ? 1'b1 : 1'b0, DIV + extra_low);
   endtask

   int t0;

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge osc);
      rst_n = 1'b1;
      level(1'b1, 10);

      // single good byte
      t0 = cyc;
      send_frame(8'hA5, 1'b1, 0);
      level(1'b1, 10);
      #2;
      check("a5_data", int'(data), 32'hA5);
      check("a5_count", n_valid, 1);
      check("a5_ferr", n_ferr, 0);
      check("a5_latency", last_valid_cyc - t0, 155);
      check("a5_link", int'(link), 1);

      // back-to-back frames, no idle gap
      @(negedge osc);
      t0 = cyc;
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      level(1'b1, 10);
      #2;
      check("b2b_count", n_valid, 3);
      check("b2b_data", int'(data), 32'hFF);
      check("b2b_gap", last_valid_cyc - t0, 315);

      // short low glitch rejected in START
      @(negedge osc);
      level(1'b0, 4);
      level(1'b1, 40);
      #2;
      check("glitch_valid", n_valid, 3);
      check("glitch_ferr", n_ferr, 0);

      // bad stop bit, line held low, then a good byte
      @(negedge osc);
      t0 = cyc;
      send_frame(8'h3C, 1'b0, 40);
      level(1'b1, 20);
      #2;
      check("ferr_count", n_ferr, 1);
      check("ferr_latency", last_ferr_cyc - t0, 155);
      check("ferr_data_held", int'(data), 32'hFF);
      check("ferr_no_valid", n_valid, 3);
      @(negedge osc);
      send_frame(8'h12, 1'b1, 0);
      level(1'b1, 34);
      #2;
      check("x12_data", int'(data), 32'h12);
      check("x12_count", n_valid, 4);
      check("link_hold_last", int'(link), 1);
      @(negedge osc);
      #2;
      check("link_drop", int'(link), 0);
      check("link_drop_time", cyc - last_valid_cyc, 40);

      // reset during bit 4, then a full frame
      @(negedge osc);
      level(1'b1, 5);
      level(1'b0, DIV);
      level(1'b1, DIV);
      level(1'b0, 3 * DIV);
      level(1'b1, 8);
      rst_n = 1'b0;
      level(1'b1, 4);
      rst_n = 1'b1;
      level(1'b1, 10);
      #2;
      check("rst_abort_count", n_valid, 4);
      check("rst_abort_data", int'(data), 0);
      @(negedge osc);
      send_frame(8'h81, 1'b1, 0);
      level(1'b1, 60);
      #2;
      check("x81_data", int'(data), 32'h81);
      check("x81_count", n_valid, 5);
      check("final_ferr", n_ferr, 1);
      check("model_drained", evq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
